// File: rtl/dm_access_unit_if.sv
// ============================================================================
// dm_access_unit_if : request/response bus of the data-memory access unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface dm_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        MemWrite;
  logic [2:0]  DMType;
  logic [31:0] addr;
  logic [31:0] din;
  logic        resp_valid;
  logic [31:0] dout;
  logic        misalign;

  modport master (
    output req_valid, MemWrite, DMType, addr, din,
    input  req_ready, resp_valid, dout, misalign
  );

  modport slave (
    input  req_valid, MemWrite, DMType, addr, din,
    output req_ready, resp_valid, dout, misalign
  );
endinterface

`default_nettype wire

// File: rtl/dm_access_unit.sv
// ============================================================================
// dm_access_unit : handshaked byte/half/word load-store unit, splits accesses
//                  that straddle a word boundary into two word accesses
// Revision 1.0
// ============================================================================
`default_nettype none

module dm_access_unit #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  dm_access_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC1 = 2'd1,
    S_ACC2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      type_q;
  logic [1:0]      off_q;
  logic [AW-1:0]   idx0_q;
  logic [31:0]     din_q;
  logic [31:0]     asm_q;
  logic [31:0]     dout_q;
  logic            mis_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [3:0]      w_szmask;
  logic [7:0]      w_bytemask;
  logic            w_split;
  logic [4:0]      w_sh1, w_sh2;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_rd;
  logic [3:0]      w_lane_en;
  logic [31:0]     w_wdata;
  logic            w_wr;
  logic [31:0]     w_load;

  function automatic logic [31:0] f_extend(input logic [2:0] t, input logic [31:0] v);
    case (t)
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b010:  return {16'h0000, v[15:0]};
      3'b011:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'h000000, v[7:0]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    case (type_q)
      3'b001, 3'b010: w_szmask = 4'b0011;
      3'b011, 3'b100: w_szmask = 4'b0001;
      default:        w_szmask = 4'b1111;
    endcase
  end

  // Bits [3:0] select lanes of word 0, bits [7:4] lanes of word 1.
  assign w_bytemask = {4'b0000, w_szmask} << off_q;
  assign w_split    = |w_bytemask[7:4];
  assign w_sh1      = {off_q, 3'b000};
  assign w_sh2      = {2'(3'd4 - {1'b0, off_q}), 3'b000};

  assign w_idx     = (state_q == S_ACC2) ? idx0_q + {{(AW-1){1'b0}}, 1'b1} : idx0_q;
  assign w_rd      = mem_q[w_idx];
  assign w_lane_en = (state_q == S_ACC2) ? w_bytemask[7:4] : w_bytemask[3:0];
  assign w_wdata   = (state_q == S_ACC2) ? (din_q >> w_sh2) : (din_q << w_sh1);
  assign w_wr      = we_q && ((state_q == S_ACC1) || (state_q == S_ACC2));
  assign w_load    = (state_q == S_ACC2) ? (asm_q | (w_rd << w_sh2)) : (w_rd >> w_sh1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_ACC1;
      S_ACC1:  state_d = w_split ? S_ACC2 : S_DONE;
      S_ACC2:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      idx0_q  <= '0;
      din_q   <= 32'h0;
      asm_q   <= 32'h0;
      dout_q  <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && bus.req_valid) begin
        we_q   <= bus.MemWrite;
        type_q <= bus.DMType;
        off_q  <= bus.addr[1:0];
        idx0_q <= bus.addr[AW+1:2];
        din_q  <= bus.din;
      end
      if (state_q == S_ACC1) asm_q <= w_load;
      dout_q <= ((state_d == S_DONE) && !we_q) ? f_extend(type_q, w_load) : 32'h0;
      mis_q  <= (state_d == S_DONE) ? w_split : 1'b0;
    end
  end

  // The array has no reset so contents survive a reset mid-transaction.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (w_lane_en[l]) mem_q[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.dout       = dout_q;
  assign bus.misalign   = mis_q;

endmodule

`default_nettype wire

// File: doc/dm_access_unit.md
# dm_access_unit

Data-memory access unit for the RISC-V core: the consumer end of the decoder's memory-control outputs (`MemWrite`, `DMType`). It accepts one load or store per request handshake and performs byte, halfword or word access with sign or zero extension on an internal little-endian word array. Accesses that straddle a word boundary are split automatically into two sequential word accesses. It replaces the core's single-cycle data memory when the design moves to a handshaked memory path.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array; must be a power of two.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `MemWrite` in 1: 1 = store, 0 = load.
- `DMType` in 3: access type.
  - 000 word; 001 halfword; 010 halfword unsigned; 011 byte; 100 byte unsigned.
  - 101–111 are treated as word.
- `addr` in 32: byte address.
- `din` in 32: store data, LSB-aligned.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `dout` out 32: extended load data, valid while `resp_valid` = 1; 0 for stores.
- `misalign` out 1: valid with `resp_valid`; 1 = the access was split.

## Operation
- **States:** IDLE, ACC1, ACC2, DONE. `req_ready` = 1 only in IDLE.
- **Accept:** in IDLE, when `req_valid` = 1 at an edge, latch `MemWrite`, `DMType`, `addr` and `din`, then go to ACC1. `req_valid` has no effect in any other state.
- **Size:** word = 4 bytes; halfword or halfword unsigned = 2 bytes; byte or byte unsigned = 1 byte.
- **Offset:** `off` = `addr[1:0]`.
- **Split condition:** the access is split when `off` + size > 4. This happens for a word at offset 1–3 or a halfword at offset 3. Bytes never split.
- **Word index:** word 0 index = `addr[31:2]` mod `DEPTH_WORDS`. Word 1 index = (word 0 index + 1) mod `DEPTH_WORDS`, so it wraps from the last word to word 0. Upper address bits are ignored.
- **Byte order:** byte k of the access sits at byte address `addr` + k. Byte lane within a word = address mod 4, with lane 0 = bits [7:0].
- **ACC1:** access word 0.
  - Store: write only the lanes from `off` up to min(3, `off` + size − 1), taking `din` bytes in order from byte 0.
  - Load: capture the same lanes into an assembly register.
  - Next state: ACC2 if split, else DONE.
- **ACC2:** access word 1, lanes 0 through (`off` + size − 5), continuing with the next `din` bytes or assembly bytes. Next state: DONE.
- **DONE:**
  - `resp_valid` = 1.
  - `misalign` = split flag.
  - `dout` = load data, extended per the signed/unsigned rules below.
  - Next state: IDLE.
- **Load extension:**
  - Byte: sign-extend from bit 7.
  - Byte unsigned: zero-extend.
  - Halfword: sign-extend from bit 15.
  - Halfword unsigned: zero-extend.
  - Word: unchanged.
- **Array contents:** not cleared by reset; contents after power-up are undefined. Unwritten lanes are never modified.
- **Reset:** asynchronous and effective in any state.
  - State goes to IDLE; `resp_valid`, `misalign` and `dout` go to 0.
  - Any pending response is dropped.
  - A split store interrupted after ACC1 leaves word 0 updated and word 1 untouched.

## Timing
- **Reset values:** `req_ready` = 1, `resp_valid` = 0, `dout` = 0, `misalign` = 0.
- **Non-split request accepted at edge T:**
  - word accessed at edge T+1;
  - `resp_valid` high for the one cycle between edges T+2 and T+3 is not used; it is high during the cycle after edge T+1 only (1 cycle);
  - `req_ready` returns to 1 after edge T+2.
- **Split request accepted at edge T:**
  - words accessed at edges T+1 and T+2;
  - `resp_valid` high during the cycle after edge T+2;
  - IDLE after edge T+3.
- **Throughput:** one request every 3 cycles for non-split accesses, every 4 cycles for split accesses.
- **Read-after-write:** a load issued after a store's `resp_valid` observes the stored data.
- **Output timing:** all outputs are registered or decoded from state; there is no combinational path from request inputs to outputs.

## Test plan
- **Word store/load:**
  - Stimulus: after reset, store word 0x12345678 at 0x10, then load word at 0x10.
  - Required: `dout` = 0x12345678, `misalign` = 0, `resp_valid` one cycle after the edge following acceptance, `req_ready` low for exactly 2 cycles.
- **Byte sign/zero extension:**
  - Store byte 0x80 at 0x12; load byte at 0x12 → 0xFFFFFF80; load byte unsigned at 0x12 → 0x00000080.
  - Load byte at 0x11 → 0x00000056. Word 0x10 now reads 0x12805678.
- **Split halfword load:**
  - Setup: word 0x10 = 0x12345678, word 0x14 = 0xAABBCCDD.
  - Halfword load at 0x13 → 0xFFFFDD12; halfword unsigned load at 0x13 → 0x0000DD12.
  - Both with `misalign` = 1 and `resp_valid` two edges after the first access edge.
- **Split word store:**
  - Same setup; store word 0xCAFEBABE at 0x11.
  - Load word 0x10 → 0xFEBABE78; load word 0x14 → 0xAABBCCCA.
- **Wrap-around:**
  - With `DEPTH_WORDS` = 1024, store word 0x11223344 at 0xFFE.
  - Word index 1023 reads 0x3344xxxx in bytes 2–3; word 0 reads 0xxxxx1122 in bytes 0–1. Other bytes unchanged.
- **Reset and busy behaviour:**
  - Assert `rst` during ACC2 of a split store → `resp_valid` never pulses, `req_ready` = 1 immediately, word 0 updated, word 1 unchanged.
  - Hold `req_valid` high while busy → exactly one request accepted per return to IDLE.
